// File: rtl/avalon_gpio_pio.sv
// Avalon-MM GPIO slave: per-bit direction, synchronised inputs, edge capture and maskable IRQ.
// Optional OUTSET/OUTCLR registers at word offsets 4/5 are enabled by defining PIO_BITSET_EN.
module avalon_gpio_pio #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] DATA_RESET = '0,
  parameter logic [WIDTH-1:0] DIR_RESET  = '0,
  parameter int               EDGE_TYPE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe_port,
  output logic             irq
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] s1_q, s2_q, s3_q;
  logic [1:0]       settle_q, settle_d;
  logic [WIDTH-1:0] det_sel, det, clr, wdata;
  logic             wr, settle_done;
  logic [31:0]      unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = writedata;
  assign settle_done  = (settle_q == 2'd3);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_edge
      logic rise, fall;
      assign rise = s2_q[gi] & ~s3_q[gi];
      assign fall = ~s2_q[gi] & s3_q[gi];
      if (EDGE_TYPE == 0) begin : g_rise
        assign det_sel[gi] = rise;
      end else if (EDGE_TYPE == 1) begin : g_fall
        assign det_sel[gi] = fall;
      end else begin : g_any
        assign det_sel[gi] = rise | fall;
      end
    end
  endgenerate

  // Sync flops come out of reset at zero; ignore edges until they hold real pin history.
  assign det = settle_done ? det_sel : '0;
  assign clr = (wr && address == 3'd3) ? wdata : '0;

  always_comb begin
    data_d   = data_q;
    dir_d    = dir_q;
    mask_d   = mask_q;
    settle_d = settle_done ? settle_q : settle_q + 2'd1;
    cap_d    = (cap_q & ~clr) | det;
    if (wr) begin
      case (address)
        3'd0: data_d = wdata;
        3'd1: dir_d  = wdata;
        3'd2: mask_d = wdata;
`ifdef PIO_BITSET_EN
        3'd4: data_d = data_q | wdata;
        3'd5: data_d = data_q & ~wdata;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= DATA_RESET;
      dir_q    <= DIR_RESET;
      mask_q   <= '0;
      cap_q    <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      settle_q <= '0;
    end else begin
      data_q   <= data_d;
      dir_q    <= dir_d;
      mask_q   <= mask_d;
      cap_q    <= cap_d;
      s1_q     <= in_port;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      settle_q <= settle_d;
    end
  end

  always_comb begin
    readdata = '0;
    if (chipselect) begin
      case (address)
        3'd0: readdata[WIDTH-1:0] = (s2_q & ~dir_q) | (data_q & dir_q);
        3'd1: readdata[WIDTH-1:0] = dir_q;
        3'd2: readdata[WIDTH-1:0] = mask_q;
        3'd3: readdata[WIDTH-1:0] = cap_q;
        default: ;
      endcase
    end
  end

  assign out_port = data_q;
  assign oe_port  = dir_q;
  assign irq      = |(cap_q & mask_q);

endmodule
